// File: rtl/id_stage_pipe_if.sv
// Bundles the ID-stage pipeline signals: the IF/ID, EX/MEM and MEM/WB inputs and the ID/EX, stall and redirect outputs.
// The slave modport is the decode stage. The master modport is whatever drives it.
interface id_stage_pipe_if #(
  parameter int XLEN = 32
);
  logic            if_valid;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic [4:0]      mem_rd;
  logic            mem_regwrite;
  logic            mem_memread;
  logic [XLEN-1:0] mem_result;
  logic [4:0]      wb_rd;
  logic            wb_we;
  logic [XLEN-1:0] wb_data;

  logic            id_ex_valid;
  logic [7:0]      id_ex_ctrl;
  logic [XLEN-1:0] id_ex_rdata1;
  logic [XLEN-1:0] id_ex_rdata2;
  logic [XLEN-1:0] id_ex_imm;
  logic [XLEN-1:0] id_ex_pc;
  logic [4:0]      id_ex_rs;
  logic [4:0]      id_ex_rt;
  logic [4:0]      id_ex_rd;
  logic            stall_if;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;

  modport master (
    output if_valid, if_instr, if_pc, mem_rd, mem_regwrite, mem_memread, mem_result,
           wb_rd, wb_we, wb_data,
    input  id_ex_valid, id_ex_ctrl, id_ex_rdata1, id_ex_rdata2, id_ex_imm, id_ex_pc,
           id_ex_rs, id_ex_rt, id_ex_rd, stall_if, branch_taken, branch_target
  );

  modport slave (
    input  if_valid, if_instr, if_pc, mem_rd, mem_regwrite, mem_memread, mem_result,
           wb_rd, wb_we, wb_data,
    output id_ex_valid, id_ex_ctrl, id_ex_rdata1, id_ex_rdata2, id_ex_imm, id_ex_pc,
           id_ex_rs, id_ex_rt, id_ex_rd, stall_if, branch_taken, branch_target
  );
endinterface

// File: rtl/id_stage_pipe.sv
// MIPS-style ID stage: decode, register file, hazard stall FSM and early beq resolution.
// Defining ID_RF_BYPASS_EN routes same-cycle write-back data to the ID/EX operands.
//
// state | meaning
// RUN   | ID/EX accepts the ID instruction unless a hazard is detected
// STALL | extra load-use bubble cycles; cnt counts down the remaining ones
module id_stage_pipe #(
  parameter int XLEN       = 32,
  parameter int LOAD_STALL = 1
) (
  input logic           clk,
  input logic           rst_n,
  id_stage_pipe_if.slave bus
);
  localparam logic [0:0] S_RUN    = 1'b0;
  localparam logic [0:0] S_STALL  = 1'b1;
  localparam logic [1:0] CNT_LOAD = 2'(LOAD_STALL - 1);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;

  logic [XLEN-1:0] rf_q [32];
  logic [0:0]      state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;

  logic            id_ex_valid_q, id_ex_valid_d;
  logic [7:0]      id_ex_ctrl_q, id_ex_ctrl_d;
  logic [XLEN-1:0] id_ex_rdata1_q, id_ex_rdata1_d;
  logic [XLEN-1:0] id_ex_rdata2_q, id_ex_rdata2_d;
  logic [XLEN-1:0] id_ex_imm_q, id_ex_imm_d;
  logic [XLEN-1:0] id_ex_pc_q, id_ex_pc_d;
  logic [4:0]      id_ex_rs_q, id_ex_rs_d;
  logic [4:0]      id_ex_rt_q, id_ex_rt_d;
  logic [4:0]      id_ex_rd_q, id_ex_rd_d;

  logic [5:0]      opcode;
  logic [4:0]      rs, rt, rd;
  logic [7:0]      ctrl;
  logic            id_ok, is_beq, uses_rt;
  logic [XLEN-1:0] imm_ext;

  assign opcode  = bus.if_instr[31:26];
  assign rs      = bus.if_instr[25:21];
  assign rt      = bus.if_instr[20:16];
  assign rd      = bus.if_instr[15:11];
  assign imm_ext = {{(XLEN-16){bus.if_instr[15]}}, bus.if_instr[15:0]};

  // ctrl = {RegDst, MemRead, MemtoReg, ALUOp[1:0], MemWrite, ALUSrc, RegWrite}
  always_comb begin
    ctrl = 8'h00;
    if (bus.if_valid) begin
      case (opcode)
        OP_R:    ctrl = 8'b1001_0001;
        OP_LW:   ctrl = 8'b0110_0011;
        OP_SW:   ctrl = 8'b0000_0110;
        OP_BEQ:  ctrl = 8'b0000_1000;
        OP_ADDI: ctrl = 8'b0000_0011;
        default: ctrl = 8'h00;
      endcase
    end
  end

  assign id_ok   = (ctrl != 8'h00);
  assign is_beq  = bus.if_valid && (opcode == OP_BEQ);
  assign uses_rt = id_ok && ((opcode == OP_R) || (opcode == OP_SW) || (opcode == OP_BEQ));

  logic [XLEN-1:0] rf_a, rf_b, op_a, op_b, fwd_a, fwd_b;
  assign rf_a = (rs == 5'd0) ? '0 : rf_q[rs];
  assign rf_b = (rt == 5'd0) ? '0 : rf_q[rt];

  logic wb_hit_a, wb_hit_b, mem_hit_a, mem_hit_b;
  assign wb_hit_a  = bus.wb_we && (bus.wb_rd == rs) && (rs != 5'd0);
  assign wb_hit_b  = bus.wb_we && (bus.wb_rd == rt) && (rt != 5'd0);
  assign mem_hit_a = bus.mem_regwrite && !bus.mem_memread && (bus.mem_rd == rs) && (rs != 5'd0);
  assign mem_hit_b = bus.mem_regwrite && !bus.mem_memread && (bus.mem_rd == rt) && (rt != 5'd0);

`ifdef ID_RF_BYPASS_EN
  assign op_a = wb_hit_a ? bus.wb_data : rf_a;
  assign op_b = wb_hit_b ? bus.wb_data : rf_b;
`else
  assign op_a = rf_a;
  assign op_b = rf_b;
`endif

  assign fwd_a = mem_hit_a ? bus.mem_result : (wb_hit_a ? bus.wb_data : rf_a);
  assign fwd_b = mem_hit_b ? bus.mem_result : (wb_hit_b ? bus.wb_data : rf_b);

  logic [4:0] ex_dest;
  logic       haz_load, haz_ex, haz_mem, hazard, run, accept;
  assign ex_dest  = id_ex_ctrl_q[7] ? id_ex_rd_q : id_ex_rt_q;
  assign haz_load = id_ok && id_ex_valid_q && id_ex_ctrl_q[6] && (id_ex_rt_q != 5'd0) &&
                    ((id_ex_rt_q == rs) || (uses_rt && (id_ex_rt_q == rt)));
  assign haz_ex   = is_beq && id_ex_valid_q && id_ex_ctrl_q[0] && (ex_dest != 5'd0) &&
                    ((ex_dest == rs) || (ex_dest == rt));
  assign haz_mem  = is_beq && bus.mem_memread && (bus.mem_rd != 5'd0) &&
                    ((bus.mem_rd == rs) || (bus.mem_rd == rt));
  assign hazard   = haz_load || haz_ex || haz_mem;
  assign run      = (state_q == S_RUN);
  assign accept   = run && !hazard;

  assign bus.stall_if      = rst_n && (run ? hazard : 1'b1);
  assign bus.branch_taken  = rst_n && accept && is_beq && (fwd_a == fwd_b);
  assign bus.branch_target = bus.if_pc + (imm_ext << 2);

  // The detection cycle is the first bubble; STALL supplies the remaining LOAD_STALL-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (run) begin
      if (haz_load && (CNT_LOAD != 2'd0)) begin
        state_d = S_STALL;
        cnt_d   = CNT_LOAD;
      end
    end else if (cnt_q > 2'd1) begin
      cnt_d = cnt_q - 2'd1;
    end else begin
      state_d = S_RUN;
      cnt_d   = 2'd0;
    end
  end

  always_comb begin
    id_ex_valid_d  = 1'b0;
    id_ex_ctrl_d   = 8'h00;
    id_ex_rdata1_d = '0;
    id_ex_rdata2_d = '0;
    id_ex_imm_d    = '0;
    id_ex_pc_d     = '0;
    id_ex_rs_d     = 5'd0;
    id_ex_rt_d     = 5'd0;
    id_ex_rd_d     = 5'd0;
    if (accept && id_ok) begin
      id_ex_valid_d  = 1'b1;
      id_ex_ctrl_d   = ctrl;
      id_ex_rdata1_d = op_a;
      id_ex_rdata2_d = op_b;
      id_ex_imm_d    = imm_ext;
      id_ex_pc_d     = bus.if_pc;
      id_ex_rs_d     = rs;
      id_ex_rt_d     = rt;
      id_ex_rd_d     = rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_RUN;
      cnt_q          <= 2'd0;
      id_ex_valid_q  <= 1'b0;
      id_ex_ctrl_q   <= 8'h00;
      id_ex_rdata1_q <= '0;
      id_ex_rdata2_q <= '0;
      id_ex_imm_q    <= '0;
      id_ex_pc_q     <= '0;
      id_ex_rs_q     <= 5'd0;
      id_ex_rt_q     <= 5'd0;
      id_ex_rd_q     <= 5'd0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      id_ex_valid_q  <= id_ex_valid_d;
      id_ex_ctrl_q   <= id_ex_ctrl_d;
      id_ex_rdata1_q <= id_ex_rdata1_d;
      id_ex_rdata2_q <= id_ex_rdata2_d;
      id_ex_imm_q    <= id_ex_imm_d;
      id_ex_pc_q     <= id_ex_pc_d;
      id_ex_rs_q     <= id_ex_rs_d;
      id_ex_rt_q     <= id_ex_rt_d;
      id_ex_rd_q     <= id_ex_rd_d;
      if (bus.wb_we && (bus.wb_rd != 5'd0)) rf_q[bus.wb_rd] <= bus.wb_data;
    end
  end

  assign bus.id_ex_valid  = id_ex_valid_q;
  assign bus.id_ex_ctrl   = id_ex_ctrl_q;
  assign bus.id_ex_rdata1 = id_ex_rdata1_q;
  assign bus.id_ex_rdata2 = id_ex_rdata2_q;
  assign bus.id_ex_imm    = id_ex_imm_q;
  assign bus.id_ex_pc     = id_ex_pc_q;
  assign bus.id_ex_rs     = id_ex_rs_q;
  assign bus.id_ex_rt     = id_ex_rt_q;
  assign bus.id_ex_rd     = id_ex_rd_q;
endmodule
